updown_mm_counter: RTL and testbench

Parametrised up/down counter with a programmable limit, wrap or saturate mode, variable step, parallel load, terminal-count pulses and running max/min watermarks. It generalises the fixed-width 32-bit up/down counter into a reusable counting/tracking block for datapath and control logic in the same designs. The watermark outputs take over the counter's A/B (max/min) role.

---
 rtl/updown_mm_counter.sv | 136 +++++++++++++
 tb/tb_updown_mm_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/updown_mm_counter.sv
// rtl/updown_mm_counter.sv - up/down counter with limit, wrap/saturate, load, tc pulses and watermarks
// Optional max/min watermark tracking is built when UPDOWN_WM_EN is defined.
module updown_mm_counter #(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  sat_mode,
  input  logic                  clr_wm,
  output logic [WIDTH-1:0]      count,
  output logic                  tc_up,
  output logic                  tc_dn,
  output logic [WIDTH-1:0]      max_wm,
  output logic [WIDTH-1:0]      min_wm
);

  generate
    if (STEP_WIDTH > WIDTH) begin : g_bad_step_width
      $error("STEP_WIDTH must not exceed WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_tc_up;
  logic             r_tc_dn;

  // All arithmetic is carried one bit wider so the up-step carry is never lost.
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_count_ext;
  logic [WIDTH:0]   w_limit_ext;
  logic [WIDTH:0]   w_limit_p1;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrap_up;
  logic [WIDTH:0]   w_under;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc_up;
  logic             w_next_tc_dn;
  logic             w_write;

  assign w_step_ext  = {{(WIDTH-STEP_WIDTH+1){1'b0}}, step};
  assign w_count_ext = {1'b0, r_count};
  assign w_limit_ext = {1'b0, limit};
  assign w_limit_p1  = w_limit_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_sum       = w_count_ext + w_step_ext;
  assign w_wrap_up   = w_sum - w_limit_p1;
  assign w_under     = w_step_ext - w_count_ext;

  always_comb begin
    w_next_count = r_count;
    w_next_tc_up = 1'b0;
    w_next_tc_dn = 1'b0;
    w_write      = 1'b0;
    if (load) begin
      w_write      = 1'b1;
      w_next_count = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      w_write = 1'b1;
      if (step != '0) begin
        if (up) begin
          if (w_sum <= w_limit_ext) begin
            w_next_count = w_sum[WIDTH-1:0];
          end else begin
            w_next_tc_up = 1'b1;
            if (sat_mode || (w_wrap_up > w_limit_ext)) begin
              w_next_count = limit;
            end else begin
              w_next_count = w_wrap_up[WIDTH-1:0];
            end
          end
        end else begin
          if (w_step_ext <= w_count_ext) begin
            w_next_count = r_count - w_step_ext[WIDTH-1:0];
          end else begin
            w_next_tc_dn = 1'b1;
            // Wrapped result is limit+1-(step-count); going below zero clamps to 0.
            if (sat_mode || (w_under > w_limit_p1)) begin
              w_next_count = '0;
            end else begin
              w_next_count = w_limit_p1[WIDTH-1:0] - w_under[WIDTH-1:0];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc_up <= 1'b0;
      r_tc_dn <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc_up <= w_next_tc_up;
      r_tc_dn <= w_next_tc_dn;
    end
  end

  assign count = r_count;
  assign tc_up = r_tc_up;
  assign tc_dn = r_tc_dn;

`ifdef UPDOWN_WM_EN
  logic [WIDTH-1:0] r_max_wm;
  logic [WIDTH-1:0] r_min_wm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_max_wm <= '0;
      r_min_wm <= '0;
    end else if (clr_wm) begin
      r_max_wm <= w_next_count;
      r_min_wm <= w_next_count;
    end else if (w_write) begin
      if (w_next_count > r_max_wm) r_max_wm <= w_next_count;
      if (w_next_count < r_min_wm) r_min_wm <= w_next_count;
    end
  end

  assign max_wm = r_max_wm;
  assign min_wm = r_min_wm;
`else
  logic w_unused_clr_wm;
  assign w_unused_clr_wm = clr_wm;
  assign max_wm = '0;
  assign min_wm = '0;
`endif

endmodule

// File: tb/tb_updown_mm_counter.sv
// tb/tb_updown_mm_counter.sv - directed self-checking bench for updown_mm_counter
// Watermark expectations follow whether UPDOWN_WM_EN is defined for the build.
module tb_updown_mm_counter;

  localparam int WIDTH      = 8;
  localparam int STEP_WIDTH = 4;
`ifdef UPDOWN_WM_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [STEP_WIDTH-1:0] step;
  logic [WIDTH-1:0]      limit;
  logic                  sat_mode;
  logic                  clr_wm;
  logic [WIDTH-1:0]      count;
  logic                  tc_up;
  logic                  tc_dn;
  logic [WIDTH-1:0]      max_wm;
  logic [WIDTH-1:0]      min_wm;

  int n_checks = 0;
  int n_fails  = 0;

  updown_mm_counter #(.WIDTH(WIDTH), .STEP_WIDTH(STEP_WIDTH)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .step(step), .limit(limit), .sat_mode(sat_mode),
    .clr_wm(clr_wm), .count(count), .tc_up(tc_up), .tc_dn(tc_dn),
    .max_wm(max_wm), .min_wm(min_wm)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] lim, input logic [WIDTH-1:0] val);
    limit = lim; load_val = val; load = 1'b1; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    step = '0; limit = '0; sat_mode = 1'b0; clr_wm = 1'b0;
    tick();
    tick();
    check_val("rst_count", count, 0);
    check_val("rst_tc_up", tc_up, 0);
    check_val("rst_tc_dn", tc_dn, 0);
    check_val("rst_max", max_wm, 0);
    check_val("rst_min", min_wm, 0);
    reset = 1'b0;

    // wrap up through limit 9
    limit = 9; sat_mode = 1'b0; up = 1'b1; step = 1; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_val($sformatf("wrap_up_count_%0d", i), count, i % 10);
      check_val($sformatf("wrap_up_tc_%0d", i), tc_up, (i == 10) ? 1 : 0);
      check_val($sformatf("wrap_up_tcdn_%0d", i), tc_dn, 0);
    end
    en = 1'b0;
    tick();
    check_val("idle_count", count, 0);
    check_val("idle_tc_up", tc_up, 0);

    // saturate up
    sat_mode = 1'b1;
    do_load(200, 198);
    check_val("sat_load", count, 198);
    step = 5; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val($sformatf("sat_up_count_%0d", i), count, 200);
      check_val($sformatf("sat_up_tc_%0d", i), tc_up, 1);
    end
    en = 1'b0;

    // wrap down
    sat_mode = 1'b0;
    do_load(9, 2);
    step = 3; up = 1'b0; en = 1'b1;
    tick();
    check_val("wrap_dn_count", count, 9);
    check_val("wrap_dn_tc_dn", tc_dn, 1);
    check_val("wrap_dn_tc_up", tc_up, 0);
    en = 1'b0;

    // saturate down
    sat_mode = 1'b1;
    do_load(9, 1);
    step = 4; up = 1'b0; en = 1'b1;
    tick();
    check_val("sat_dn_count", count, 0);
    check_val("sat_dn_tc_dn", tc_dn, 1);
    en = 1'b0;

    // load clamp beats enable
    sat_mode = 1'b0; up = 1'b1; step = 1;
    limit = 100; load_val = 250; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    check_val("load_clamp_count", count, 100);
    check_val("load_clamp_tc_up", tc_up, 0);
    check_val("load_clamp_tc_dn", tc_dn, 0);

    // limit 0: wrap result clamps to 0 and still pulses
    do_load(0, 0);
    step = 3; up = 1'b1; en = 1'b1;
    tick();
    check_val("lim0_count", count, 0);
    check_val("lim0_tc_up", tc_up, 1);
    en = 1'b0;

    // zero step holds with no pulse
    do_load(9, 5);
    step = 0; up = 1'b1; en = 1'b1;
    tick();
    check_val("step0_count", count, 5);
    check_val("step0_tc_up", tc_up, 0);
    en = 1'b0;

    // watermarks
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sat_mode = 1'b0;
    do_load(255, 50);
    step = 10; up = 1'b1; en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    check_val("wm_count", count, 80);
    check_val("wm_max", max_wm, WM ? 80 : 0);
    check_val("wm_min", min_wm, 0);
    clr_wm = 1'b1;
    tick();
    clr_wm = 1'b0;
    check_val("wm_clr_max", max_wm, WM ? 80 : 0);
    check_val("wm_clr_min", min_wm, WM ? 80 : 0);
    up = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    check_val("wm_dn_count", count, 70);
    check_val("wm_dn_max", max_wm, WM ? 80 : 0);
    check_val("wm_dn_min", min_wm, WM ? 70 : 0);

    // reset overrides everything
    do_load(255, 37);
    check_val("pre_rst_count", count, 37);
    en = 1'b1; load = 1'b1; clr_wm = 1'b1; reset = 1'b1; load_val = 99; step = 5; up = 1'b1;
    tick();
    en = 1'b0; load = 1'b0; clr_wm = 1'b0; reset = 1'b0;
    check_val("mid_rst_count", count, 0);
    check_val("mid_rst_tc_up", tc_up, 0);
    check_val("mid_rst_tc_dn", tc_dn, 0);
    check_val("mid_rst_max", max_wm, 0);
    check_val("mid_rst_min", min_wm, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
